// File: rtl/cla_pkg.sv
// Shared constants, helpers and the width-independent part of the per-stage
// pipeline record for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int SLICE_W = 4;

  // Control half of a stage record; the WIDTH-dependent operand/partial-sum
  // half lives beside it in the top, where WIDTH is known.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_ctl_t;

  function automatic int stages(input int width, input int sps);
    return width / (SLICE_W * sps);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3 so the
// most significant slice can report signed overflow.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] c;
  logic               grp_g;
  logic               grp_p;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  // Group generate/propagate let the slice carry-out skip the internal chain.
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

  assign co = grp_g | (grp_p & ci);
  assign s  = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract unit: each stage resolves SLICES_PER_STAGE CLA slices
// and registers the partial sum and inter-group carry, under a global stall.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES  = stages(WIDTH, SLICES_PER_STAGE);
  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int STAGE_W = SLICE_W * SLICES_PER_STAGE;

  // Stage registers: control record plus operands still to be added and the
  // low sum bits completed so far.
  stage_ctl_t       ctl_reg [STAGES];
  logic [WIDTH-1:0] opa_reg [STAGES];
  logic [WIDTH-1:0] opb_reg [STAGES];
  logic [WIDTH-1:0] sum_reg [STAGES];
  logic             ovf_reg;

  // What each stage sees at its input, and what it will register.
  stage_ctl_t [STAGES-1:0]            src_ctl;
  stage_ctl_t [STAGES-1:0]            ctl_next;
  logic       [STAGES-1:0][WIDTH-1:0] src_a;
  logic       [STAGES-1:0][WIDTH-1:0] src_b;
  logic       [STAGES-1:0][WIDTH-1:0] src_sum;
  logic       [STAGES-1:0][WIDTH-1:0] sum_next;

  logic [WIDTH-1:0]  slice_sum;
  logic [NSLICE-1:0] slice_co;
  logic              slice_c3 [NSLICE];
  logic              ovf_next;
  logic              advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] MASK = WIDTH'({STAGE_W{1'b1}}) << (gi * STAGE_W);

      if (gi == 0) begin : g_head
        // Subtraction forces the initial carry to 1 so that ~B + 1 == -B.
        assign src_ctl[gi] = '{valid: in_valid, sub: sub, carry: sub | Cin};
        assign src_a[gi]   = A;
        assign src_b[gi]   = B;
        assign src_sum[gi] = '0;
      end else begin : g_body
        assign src_ctl[gi] = ctl_reg[gi-1];
        assign src_a[gi]   = opa_reg[gi-1];
        assign src_b[gi]   = opb_reg[gi-1];
        assign src_sum[gi] = sum_reg[gi-1];
      end

      assign ctl_next[gi] = '{valid: src_ctl[gi].valid,
                              sub:   src_ctl[gi].sub,
                              carry: slice_co[(gi + 1) * SLICES_PER_STAGE - 1]};
      assign sum_next[gi] = (src_sum[gi] & ~MASK) | (slice_sum & MASK);
    end

    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      localparam int K   = gi / SLICES_PER_STAGE;
      localparam int LSB = gi * SLICE_W;
      logic slice_ci;

      if (gi % SLICES_PER_STAGE == 0) begin : g_first
        assign slice_ci = src_ctl[K].carry;
      end else begin : g_chain
        assign slice_ci = slice_co[gi-1];
      end

      cla4_slice u_slice (
        .a  (src_a[K][LSB +: SLICE_W]),
        .b  (src_b[K][LSB +: SLICE_W] ^ {SLICE_W{src_ctl[K].sub}}),
        .ci (slice_ci),
        .s  (slice_sum[LSB +: SLICE_W]),
        .co (slice_co[gi]),
        .c3 (slice_c3[gi])
      );
    end
  endgenerate

  assign ovf_next = slice_c3[NSLICE-1] ^ slice_co[NSLICE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_reg[k] <= '0;
        opa_reg[k] <= '0;
        opb_reg[k] <= '0;
        sum_reg[k] <= '0;
      end
      ovf_reg <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_reg[k] <= ctl_next[k];
        opa_reg[k] <= src_a[k];
        opb_reg[k] <= src_b[k];
        sum_reg[k] <= sum_next[k];
      end
      ovf_reg <= ovf_next;
    end
  end

  assign out_valid = ctl_reg[STAGES-1].valid;
  assign Sum       = sum_reg[STAGES-1];
  assign Cout      = ctl_reg[STAGES-1].carry;
  assign Ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: a 16-bit/4-stage instance and an 8-bit/1-stage
// instance, each scored against an integer-arithmetic reference model.
module tb_cla_pipe_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, cin16, sub16, ov16, ordy16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, cin8, sub8, ov8, ordy8, co8, of8;
  logic [7:0]  a8, b8, s8;

  int   checks = 0;
  int   errors = 0;
  int   got16  = 0;
  int   got8   = 0;
  int   base16, bp_n, n, bad;
  logic done16, done8;
  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .SLICES_PER_STAGE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .A(a16), .B(b16), .Cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(ordy16), .Sum(s16), .Cout(co16), .Ovf(of16)
  );

  cla_pipe_adder #(.WIDTH(8), .SLICES_PER_STAGE(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .Cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(ordy8), .Sum(s8), .Cout(co8), .Ovf(of8)
  );

  // Reference: unsigned result modulo 2^w, carry = no-borrow for sub,
  // overflow = signed result outside the w-bit two's-complement range.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sb);
    exp_t   e;
    longint ua, ub, sa, sbv, full, sres, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << w;
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sbv = (ub >= lim / 2) ? ub - lim : ub;
    if (sb) begin
      full   = ua - ub;
      e.cout = (ua >= ub);
      sres   = sa - sbv;
    end else begin
      full   = ua + ub + longint'(cin);
      e.cout = (full >= lim);
      sres   = sa + sbv + longint'(cin);
    end
    e.sum = 16'(full & (lim - 1));
    e.ovf = (sres >= lim / 2) || (sres < -(lim / 2));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ov16 && ordy16) begin
      checks++;
      assert (q16.size() != 0) else begin
        errors++; $error("FAIL out16_spurious got sum=%h exp no pending result", s16);
      end
      if (q16.size() != 0) begin
        e16 = q16.pop_front();
        checks++;
        assert ({co16, of16, s16} === {e16.cout, e16.ovf, e16.sum}) else begin
          errors++;
          $error("FAIL result16 got c=%b v=%b s=%h exp c=%b v=%b s=%h",
                 co16, of16, s16, e16.cout, e16.ovf, e16.sum);
        end
        $display("res16 #%0d sum=%h cout=%b ovf=%b", got16, s16, co16, of16);
      end
      got16++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8 && ordy8) begin
      checks++;
      assert (q8.size() != 0) else begin
        errors++; $error("FAIL out8_spurious got sum=%h exp no pending result", s8);
      end
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        checks++;
        assert ({co8, of8, s8} === {e8.cout, e8.ovf, e8.sum[7:0]}) else begin
          errors++;
          $error("FAIL result8 got c=%b v=%b s=%h exp c=%b v=%b s=%h",
                 co8, of8, s8, e8.cout, e8.ovf, e8.sum[7:0]);
        end
      end
      got8++;
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb);
    int k;
    iv16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sb;
    k = 0;
    do begin @(negedge clk); k++; end while (!ir16 && k < 100);
    checks++;
    assert (ir16 === 1'b1) else begin
      errors++; $error("FAIL accept16 got in_ready=%b exp 1", ir16);
    end
    if (ir16) q16.push_back(model(16, a, b, cin, sb));
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb);
    int k;
    iv8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sb;
    k = 0;
    do begin @(negedge clk); k++; end while (!ir8 && k < 100);
    checks++;
    assert (ir8 === 1'b1) else begin
      errors++; $error("FAIL accept8 got in_ready=%b exp 1", ir8);
    end
    if (ir8) q8.push_back(model(8, {8'h00, a}, {8'h00, b}, cin, sb));
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic run_one16(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sb,
                           input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    ordy16 = 1'b1;
    send16(a, b, cin, sb);
    lat = 1;
    while (!ov16 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks += 4;
    assert (lat == 4) else begin errors++; $error("FAIL %s_latency got %0d exp 4", tag, lat); end
    assert (s16 === es) else begin errors++; $error("FAIL %s_sum got %h exp %h", tag, s16, es); end
    assert (co16 === ec) else begin errors++; $error("FAIL %s_cout got %b exp %b", tag, co16, ec); end
    assert (of16 === eo) else begin errors++; $error("FAIL %s_ovf got %b exp %b", tag, of16, eo); end
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] corners [8];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55};
    rst_n = 1'b0;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; ordy16 = 0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; ordy8 = 1;
    done16 = 0; done8 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checks += 4;
    assert (ov16 === 1'b0) else begin errors++; $error("FAIL rst_valid got %b exp 0", ov16); end
    assert (s16 === 16'h0) else begin errors++; $error("FAIL rst_sum got %h exp 0000", s16); end
    assert (co16 === 1'b0) else begin errors++; $error("FAIL rst_cout got %b exp 0", co16); end
    assert (of16 === 1'b0) else begin errors++; $error("FAIL rst_ovf got %b exp 0", of16); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    assert (ir16 === 1'b1) else begin errors++; $error("FAIL rst_ready16 got %b exp 1", ir16); end
    assert (ir8 === 1'b1) else begin errors++; $error("FAIL rst_ready8 got %b exp 1", ir8); end
    @(posedge clk); #1;

    // Directed arithmetic with latency
    run_one16("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one16("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one16("add_cin",   16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Backpressure: 8 back-to-back ops, 5-cycle stall after the 2nd result
    base16 = got16;
    fork
      begin
        for (int i = 0; i < 8; i++) send16(16'(i), 16'(i * 3), 1'b0, 1'b0);
      end
      begin
        bp_n = 0;
        while (got16 < base16 + 2 && bp_n < 100) begin @(posedge clk); bp_n++; end
        #1 ordy16 = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks += 3;
          assert (ir16 === 1'b0) else begin errors++; $error("FAIL bp_ready got %b exp 0", ir16); end
          assert (ov16 === 1'b1) else begin errors++; $error("FAIL bp_valid got %b exp 1", ov16); end
          assert (s16 === 16'h0008) else begin errors++; $error("FAIL bp_hold got %h exp 0008", s16); end
        end
        @(posedge clk); #1 ordy16 = 1'b1;
      end
    join
    n = 0;
    while (got16 < base16 + 8 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    assert (got16 - base16 == 8) else begin
      errors++; $error("FAIL bp_count got %0d exp 8", got16 - base16);
    end

    // Random 16-bit traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 200; i++)
          send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        done16 = 1'b1;
      end
      begin
        while (!done16) begin @(posedge clk); #1; ordy16 = ($urandom_range(0, 3) != 0); end
        ordy16 = 1'b1;
      end
    join
    n = 0;
    while (q16.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    assert (q16.size() == 0) else begin errors++; $error("FAIL drain16 got %0d pending exp 0", q16.size()); end

    // Reset mid-flight
    ordy16 = 1'b0;
    for (int i = 0; i < 3; i++) send16(16'(100 + i), 16'(7), 1'b0, 1'b0);
    n = 0;
    while (!ov16 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    assert (ov16 === 1'b1) else begin errors++; $error("FAIL mid_valid got %b exp 1", ov16); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert (ov16 === 1'b0) else begin errors++; $error("FAIL mid_async got %b exp 0", ov16); end
    q16.delete();
    @(posedge clk); #1 rst_n = 1'b1; ordy16 = 1'b1;
    bad = 0;
    repeat (10) begin @(negedge clk); if (ov16) bad++; end
    checks++;
    assert (bad == 0) else begin errors++; $error("FAIL mid_stale got %0d results exp 0", bad); end
    @(posedge clk); #1;

    // 8-bit single-stage instance: latency 1
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    checks += 2;
    assert (ov8 === 1'b1) else begin errors++; $error("FAIL lat8_valid got %b exp 1", ov8); end
    assert ({co8, s8} === 9'h100) else begin errors++; $error("FAIL lat8_sum got %h exp 100", {co8, s8}); end
    @(posedge clk); #1;

    // 8-bit corner sweep plus random operands with random stalls
    fork
      begin
        for (int ia = 0; ia < 8; ia++)
          for (int ib = 0; ib < 8; ib++)
            for (int m = 0; m < 4; m++)
              send8(corners[ia], corners[ib], m[0], m[1]);
        for (int i = 0; i < 1500; i++)
          send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        done8 = 1'b1;
      end
      begin
        while (!done8) begin @(posedge clk); #1; ordy8 = ($urandom_range(0, 3) != 0); end
        ordy8 = 1'b1;
      end
    join
    n = 0;
    while (q8.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    assert (q8.size() == 0) else begin errors++; $error("FAIL drain8 got %0d pending exp 0", q8.size()); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
